// File: rtl/demux_pipe_if.sv
// demux_pipe_if: steered-stream bundle between one producer and OUTPUTS consumers.
// The in_bcast wire exists only when DEMUX_BCAST_EN is defined.
interface demux_pipe_if #(
    parameter int WIDTH   = 32,
    parameter int OUTPUTS = 4,
    parameter int WSEL    = $clog2(OUTPUTS)
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_data;
    logic [WSEL-1:0]          in_select;
`ifdef DEMUX_BCAST_EN
    logic                     in_bcast;
`endif
    logic [OUTPUTS-1:0]       out_valid;
    logic [OUTPUTS-1:0]       out_ready;
    logic [WIDTH*OUTPUTS-1:0] out_data;
    logic                     err_badsel;

    modport slave (
`ifdef DEMUX_BCAST_EN
        input  in_bcast,
`endif
        input  in_valid, in_data, in_select, out_ready,
        output in_ready, out_valid, out_data, err_badsel
    );

    modport master (
`ifdef DEMUX_BCAST_EN
        output in_bcast,
`endif
        output in_valid, in_data, in_select, out_ready,
        input  in_ready, out_valid, out_data, err_badsel
    );
endinterface

// File: rtl/demux_pipe.sv
// demux_pipe: registered 1-to-N demux with a one-entry holding register per channel.
// Optional broadcast to all channels is enabled by defining DEMUX_BCAST_EN.
module demux_pipe #(
    parameter int WIDTH   = 32,
    parameter int OUTPUTS = 4,
    parameter int WSEL    = $clog2(OUTPUTS)
) (
    input logic        clk,
    input logic        reset,
    demux_pipe_if.slave bus
);
    localparam int CODES = 2 ** WSEL;
    typedef enum logic {EMPTY, FULL} state_t;
    state_t                   state    [OUTPUTS];
    state_t                   state_nx [OUTPUTS];
    logic [OUTPUTS-1:0]       valid, free, load;
    logic [CODES-1:0]         code_ok, free_code, hit;
    logic                     bcast, bad, accept, err;
    logic [WIDTH*OUTPUTS-1:0] data;

`ifdef DEMUX_BCAST_EN
    assign bcast = bus.in_bcast;
`else
    assign bcast = 1'b0;
`endif

    // Select codes past OUTPUTS exist only when OUTPUTS is not a power of two.
    for (genvar i = 0; i < CODES; i++) begin : g_code
        assign code_ok[i] = (i < OUTPUTS);
    end

    always_comb begin
        for (int k = 0; k < OUTPUTS; k++) valid[k] = (state[k] == FULL);
        free         = ~valid | bus.out_ready;
        free_code    = CODES'(free);
        hit          = CODES'(1) << bus.in_select;
        bad          = ~code_ok[bus.in_select];
        bus.in_ready = bcast ? &free : bad | free_code[bus.in_select];
        accept       = bus.in_valid & bus.in_ready & ~reset;
        load         = ~accept ? '0 : bcast ? '1 : OUTPUTS'(hit & code_ok);
        for (int k = 0; k < OUTPUTS; k++)
            state_nx[k] = load[k] ? FULL : bus.out_ready[k] ? EMPTY : state[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= '{default: EMPTY};
            data  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= accept & bad & ~bcast;
            for (int k = 0; k < OUTPUTS; k++)
                if (load[k]) data[k*WIDTH +: WIDTH] <= bus.in_data;
        end
    end

    assign bus.out_valid  = valid;
    assign bus.out_data   = data;
    assign bus.err_badsel = err;
endmodule

// File: tb/tb_demux_pipe.sv
// tb_demux_pipe: directed and random traffic against a scoreboarded channel model,
// plus bad-select checks on a 3-channel instance.
module tb_demux_pipe;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        int          ch;
        logic [31:0] d;
    } beat_t;

    beat_t       sb [$];
    logic [3:0]  ev;
    logic [31:0] elast [4];

    demux_pipe_if #(.WIDTH(32), .OUTPUTS(4))           b ();
    demux_pipe_if #(.WIDTH(8), .OUTPUTS(3), .WSEL(2))  c ();

    demux_pipe #(.WIDTH(32), .OUTPUTS(4))          dut  (.clk(clk), .reset(reset), .bus(b));
    demux_pipe #(.WIDTH(8), .OUTPUTS(3), .WSEL(2)) dut3 (.clk(clk), .reset(reset), .bus(c));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: checks at negedge against the model, then advances it.
    task automatic step(input logic v, input logic [1:0] sel, input logic [31:0] d,
                        input logic [3:0] rdy, input logic bc, input logic rs);
        logic [3:0] fr;
        logic       er, acc;
        int         idx;
        b.in_valid  = v;
        b.in_select = sel;
        b.in_data   = d;
        b.out_ready = rdy;
`ifdef DEMUX_BCAST_EN
        b.in_bcast  = bc;
`endif
        reset = rs;
        @(negedge clk);
        fr = ~ev | rdy;
        er = bc ? &fr : fr[sel];
        chk("in_ready", {127'b0, b.in_ready}, {127'b0, er});
        chk("out_valid", {124'b0, b.out_valid}, {124'b0, ev});
        for (int k = 0; k < 4; k++)
            chk($sformatf("out_data%0d", k), {96'b0, b.out_data[k*32 +: 32]}, {96'b0, elast[k]});
        chk("err_badsel", {127'b0, b.err_badsel}, 128'b0);
        acc = v & er & ~rs;
        if (rs) begin
            ev = '0;
            foreach (elast[k]) elast[k] = '0;
            sb.delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (ev[k] & rdy[k]) begin
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++)
                        if (idx < 0 && sb[i].ch == k) idx = i;
                    chk($sformatf("drain%0d", k), {96'b0, b.out_data[k*32 +: 32]},
                        {96'b0, (idx >= 0) ? sb[idx].d : 32'hBAD0BAD0});
                    if (idx >= 0) sb.delete(idx);
                    ev[k] = 1'b0;
                end
            end
            if (acc)
                for (int k = 0; k < 4; k++)
                    if (bc || sel == 2'(k)) begin
                        sb.push_back('{ch: k, d: d});
                        ev[k]    = 1'b1;
                        elast[k] = d;
                    end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        b.in_valid  = 1'b0;
        b.in_select = '0;
        b.in_data   = '0;
        b.out_ready = '0;
        c.in_valid  = 1'b0;
        c.in_select = '0;
        c.in_data   = '0;
        c.out_ready = '0;
`ifdef DEMUX_BCAST_EN
        b.in_bcast  = 1'b0;
        c.in_bcast  = 1'b0;
`endif
        ev = '0;
        foreach (elast[k]) elast[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        step(1'b0, 2'd0, 32'h0, 4'hF, 1'b0, 1'b0);

        // single route
        step(1'b1, 2'd2, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
        chk("route_valid", {124'b0, b.out_valid}, {124'b0, 4'b0100});
        chk("route_data", {96'b0, b.out_data[64 +: 32]}, {96'b0, 32'hDEADBEEF});
        step(1'b0, 2'd0, 32'h0, 4'hF, 1'b0, 1'b0);
        chk("route_empty", {124'b0, b.out_valid}, 128'b0);

        // reset mid-traffic
        step(1'b1, 2'd0, 32'hA0A0A0A0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 2'd2, 32'hB2B2B2B2, 4'h0, 1'b0, 1'b0);
        chk("two_full", {124'b0, b.out_valid}, {124'b0, 4'b0101});
        step(1'b0, 2'd0, 32'h0, 4'h0, 1'b0, 1'b1);
        chk("rst_valid", {124'b0, b.out_valid}, 128'b0);
        chk("rst_data", b.out_data, 128'b0);
        chk("rst_err", {127'b0, b.err_badsel}, 128'b0);

        // backpressure on channel 1, channel 3 still accepts
        step(1'b1, 2'd1, 32'hC1C1C1C1, 4'h0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 32'hD1D1D1D1, 4'h0, 1'b0, 1'b0);
        step(1'b1, 2'd3, 32'hE3E3E3E3, 4'h0, 1'b0, 1'b0);
        chk("bp_valid", {124'b0, b.out_valid}, {124'b0, 4'b1010});
        chk("bp_data1", {96'b0, b.out_data[32 +: 32]}, {96'b0, 32'hC1C1C1C1});
        chk("bp_data3", {96'b0, b.out_data[96 +: 32]}, {96'b0, 32'hE3E3E3E3});
        step(1'b0, 2'd0, 32'h0, 4'hF, 1'b0, 1'b0);

        // refill on drain and streaming
        step(1'b1, 2'd0, 32'h0000000A, 4'hF, 1'b0, 1'b0);
        step(1'b1, 2'd0, 32'h0000000B, 4'hF, 1'b0, 1'b0);
        chk("refill_valid", {127'b0, b.out_valid[0]}, {127'b0, 1'b1});
        chk("refill_data", {96'b0, b.out_data[31:0]}, {96'b0, 32'h0000000B});
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2'd0, 32'h100 + 32'(i), 4'hF, 1'b0, 1'b0);
            chk("stream_data", {96'b0, b.out_data[31:0]}, {96'b0, 32'h100 + 32'(i)});
        end
        step(1'b0, 2'd0, 32'h0, 4'hF, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        step(1'b0, 2'd0, 32'h0, 4'hF, 1'b0, 1'b0);
        step(1'b0, 2'd0, 32'h0, 4'hF, 1'b0, 1'b0);
        chk("rand_drained", {124'b0, b.out_valid}, 128'b0);

`ifdef DEMUX_BCAST_EN
        step(1'b1, 2'd2, 32'hC2C2C2C2, 4'h0, 1'b0, 1'b0);
        step(1'b1, 2'd0, 32'h77777777, 4'b1011, 1'b1, 1'b0);
        chk("bc_blocked", {124'b0, b.out_valid}, {124'b0, 4'b0100});
        step(1'b1, 2'd0, 32'h77777777, 4'b1111, 1'b1, 1'b0);
        chk("bc_valid", {124'b0, b.out_valid}, {124'b0, 4'b1111});
        chk("bc_data", b.out_data, {4{32'h77777777}});
        step(1'b0, 2'd0, 32'h0, 4'hF, 1'b0, 1'b0);
`endif

        // bad select on the 3-channel instance
        c.in_valid  = 1'b1;
        c.in_select = 2'd3;
        c.in_data   = 8'h5A;
        @(negedge clk);
        chk("bad_ready", {127'b0, c.in_ready}, {127'b0, 1'b1});
        chk("bad_err_pre", {127'b0, c.err_badsel}, 128'b0);
        @(posedge clk);
        #1;
        c.in_valid = 1'b0;
        @(negedge clk);
        chk("bad_err", {127'b0, c.err_badsel}, {127'b0, 1'b1});
        chk("bad_valid", {125'b0, c.out_valid}, 128'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bad_err_post", {127'b0, c.err_badsel}, 128'b0);
        @(posedge clk);
        #1;
        c.in_valid  = 1'b1;
        c.in_select = 2'd1;
        c.in_data   = 8'h33;
        @(posedge clk);
        #1;
        c.in_select = 2'd3;
        @(negedge clk);
        chk("good3_valid", {125'b0, c.out_valid}, {125'b0, 3'b010});
        chk("good3_data", {120'b0, c.out_data[15:8]}, {120'b0, 8'h33});
        chk("good3_err", {127'b0, c.err_badsel}, 128'b0);
        chk("bad_full_ready", {127'b0, c.in_ready}, {127'b0, 1'b1});
        @(posedge clk);
        #1;
        c.in_valid = 1'b0;
        @(negedge clk);
        chk("bad_full_err", {127'b0, c.err_badsel}, {127'b0, 1'b1});
        chk("bad_full_valid", {125'b0, c.out_valid}, {125'b0, 3'b010});
        chk("bad_full_data", {120'b0, c.out_data[15:8]}, {120'b0, 8'h33});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
